// File: rtl/drive_ext_burst_if.sv
// Request/status handshake of the burst drive.
// The shared tristate data bus is a separate inout port on the drive itself.
interface drive_ext_burst_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 8
);
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              req;
  logic              we;
  logic              oe;
  logic              stb;
  logic              busy;
  logic              xfer;
  logic              done;
  logic              err;

  modport master (
    output addr, len, req, we, oe, stb,
    input  busy, xfer, done, err
  );

  modport slave (
    input  addr, len, req, we, oe, stb,
    output busy, xfer, done, err
  );
endinterface

// File: rtl/drive_ext_burst.sv
// Word-addressed burst storage peripheral on a shared tristate data bus:
// request/accept with range check, programmable seek delay, strobed beats.
module drive_ext_burst #(
  parameter int    DATA_W      = 16,
  parameter int    ADDR_W      = 24,
  parameter int    DEPTH       = 2**24,
  parameter int    LEN_W       = 8,
  parameter int    SEEK_CYCLES = 4,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              r,
  inout  wire  [DATA_W-1:0] bus,
  drive_ext_burst_if.slave  bif
);

  localparam int SEEK_W = (SEEK_CYCLES > 1) ? $clog2(SEEK_CYCLES) : 1;
  localparam logic [SEEK_W-1:0] SEEK_LOAD = SEEK_W'((SEEK_CYCLES > 0) ? SEEK_CYCLES - 1 : 0);
  localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_XFER,
    ST_DONE
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_d;
  logic [LEN_W-1:0]    remain, remain_d;
  logic [SEEK_W-1:0]   seek_cnt, seek_cnt_d;
  logic                op_we, op_we_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]     end_addr;
  logic                in_range;
  logic                beat;
  logic                drive_bus;

  // One extra address bit so addr+len cannot wrap past the top of the store.
  assign end_addr = {1'b0, bif.addr} + (ADDR_W+1)'(bif.len);
  assign in_range = (end_addr <= LAST_ADDR);

  // A read beat needs the master listening (oe); a write beat only needs stb.
  assign beat      = (state == ST_XFER) && bif.stb && (op_we || bif.oe);
  assign drive_bus = (state == ST_XFER) && !op_we && bif.oe;

  always_comb begin
    state_d    = state;
    cur_addr_d = cur_addr;
    remain_d   = remain;
    seek_cnt_d = seek_cnt;
    op_we_d    = op_we;
    err_d      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bif.req) begin
          if (in_range) begin
            cur_addr_d = bif.addr;
            remain_d   = bif.len;
            op_we_d    = bif.we;
            seek_cnt_d = SEEK_LOAD;
            if (SEEK_CYCLES == 0) state_d = ST_XFER;
            else                  state_d = ST_SEEK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEEK: begin
        if (seek_cnt == '0) state_d = ST_XFER;
        else                seek_cnt_d = seek_cnt - 1'b1;
      end
      ST_XFER: begin
        if (beat) begin
          if (remain == '0) begin
            state_d = ST_DONE;
          end else begin
            cur_addr_d = cur_addr + 1'b1;
            remain_d   = remain - 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      remain   <= '0;
      seek_cnt <= '0;
      op_we    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      cur_addr <= cur_addr_d;
      remain   <= remain_d;
      seek_cnt <= seek_cnt_d;
      op_we    <= op_we_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately outside reset: completed beats survive an abort.
  always_ff @(posedge clk) begin
    if (beat && op_we) mem[cur_addr] <= bus;
  end

  assign bus = drive_bus ? mem[cur_addr] : {DATA_W{1'bz}};

  assign bif.busy = (state != ST_IDLE);
  assign bif.xfer = (state == ST_XFER);
  assign bif.done = (state == ST_DONE);
  assign bif.err  = err_q;

endmodule

// File: tb/tb_drive_ext_burst.sv
// Bench for drive_ext_burst: one instance with a 4-cycle seek, one with none,
// both on a 256-word store, checked against a transaction-level memory model.
module tb_drive_ext_burst;

  logic        clk = 1'b0;
  logic        r   = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  addr = '0;
  logic [3:0]  len  = '0;
  logic        req = 1'b0, we = 1'b0, oe = 1'b0, stb = 1'b0, tb_en = 1'b0;
  logic [15:0] tb_dat = '0;

  wire [15:0] bus4, bus0, bus_s;
  wire        busy_s, xfer_s, done_s, err_s;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mdl  [2][256];
  logic [15:0] wdat [16];

  drive_ext_burst_if #(.ADDR_W(8), .LEN_W(4)) if4 ();
  drive_ext_burst_if #(.ADDR_W(8), .LEN_W(4)) if0 ();

  assign if4.addr = addr; assign if0.addr = addr;
  assign if4.len  = len;  assign if0.len  = len;
  assign if4.we   = we;   assign if0.we   = we;
  assign if4.oe   = oe;   assign if0.oe   = oe;
  assign if4.stb  = stb;  assign if0.stb  = stb;
  assign if4.req  = req & ~sel;
  assign if0.req  = req & sel;

  assign bus4 = (tb_en && !sel) ? tb_dat : 16'hzzzz;
  assign bus0 = (tb_en &&  sel) ? tb_dat : 16'hzzzz;

  assign bus_s  = sel ? bus0 : bus4;
  assign busy_s = sel ? if0.busy : if4.busy;
  assign xfer_s = sel ? if0.xfer : if4.xfer;
  assign done_s = sel ? if0.done : if4.done;
  assign err_s  = sel ? if0.err  : if4.err;

  drive_ext_burst #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .LEN_W(4),
                    .SEEK_CYCLES(4), .INIT_FILE("")) u4 (
    .clk(clk), .r(r), .bus(bus4), .bif(if4));

  drive_ext_burst #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .LEN_W(4),
                    .SEEK_CYCLES(0), .INIT_FILE("")) u0 (
    .clk(clk), .r(r), .bus(bus0), .bif(if0));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (sel=%0d t=%0t)", nm, act, exp, sel, $time);
    end
  endtask

  task automatic chk_z(input string nm);
    logic [15:0] v;
    v = bus_s;
    n_chk++;
    if (!(v === 16'h0000 || v === 16'hzzzz)) begin
      n_fail++;
      $display("FAIL %s: bus=%h required high-Z (sel=%0d t=%0t)", nm, v, sel, $time);
    end
  endtask

  // Complete burst from the current negedge; gap<0 gives random stalls.
  // abort_after>=0 asserts reset once that many beats have completed.
  task automatic do_burst(input int a, input int l, input bit w, input int gap, input int abort_after);
    int k;
    int g;
    int s;
    s = sel ? 0 : 4;
    addr = 8'(a); len = 4'(l); we = w; req = 1'b1; stb = 1'b0; oe = 1'b0; tb_en = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", busy_s, 1);
    k = 0;
    while (!xfer_s && k < 50) begin
      req = 1'($urandom); stb = 1'($urandom); oe = 1'($urandom);
      k++;
      @(negedge clk);
    end
    req = 1'b0;
    chk("seek_latency", k, s);
    if (!xfer_s) return;
    for (int i = 0; i <= l; i++) begin
      if (i == abort_after) begin
        stb = 1'b0; tb_en = 1'b0; oe = 1'b1;
        #2 r = 1'b0;
        #1;
        chk("abort_busy", busy_s, 0);
        chk("abort_xfer", xfer_s, 0);
        chk("abort_done", done_s, 0);
        chk_z("abort_bus");
        @(negedge clk);
        r = 1'b1; oe = 1'b0;
        @(negedge clk);
        return;
      end
      g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
      for (int j = 0; j < g; j++) begin
        if (w) begin
          stb = 1'b0; tb_en = 1'($urandom); tb_dat = 16'($urandom);
        end else begin
          stb = (gap >= 0) ? 1'b1 : 1'($urandom); oe = 1'b0; tb_en = 1'b0;
        end
        #1;
        chk("stall_xfer", xfer_s, 1);
        if (!w) chk_z("stall_bus");
        @(negedge clk);
      end
      stb = 1'b1; oe = !w; tb_en = w; tb_dat = wdat[i];
      #1;
      if (w) mdl[sel][a+i] = wdat[i];
      else   chk("read_data", bus_s, mdl[sel][a+i]);
      @(negedge clk);
    end
    stb = 1'b0; oe = 1'b0; tb_en = 1'b0;
    #1;
    chk("done_pulse", done_s, 1);
    chk("done_busy", busy_s, 1);
    chk("done_xfer", xfer_s, 0);
    @(negedge clk);
    chk("idle_done", done_s, 0);
    chk("idle_busy", busy_s, 0);
  endtask

  typedef struct {
    int a;
    int l;
    bit w;
    bit exp_err;
  } rng_t;

  rng_t rt [7];

  initial begin
    int a;
    int l;
    bit w;

    rt[0] = '{254, 1, 1'b0, 1'b0};
    rt[1] = '{255, 1, 1'b1, 1'b1};
    rt[2] = '{255, 0, 1'b0, 1'b0};
    rt[3] = '{240, 15, 1'b0, 1'b0};
    rt[4] = '{241, 15, 1'b1, 1'b1};
    rt[5] = '{250, 9, 1'b1, 1'b1};
    rt[6] = '{0, 15, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_s, 0);
    chk("rst_xfer", xfer_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_err", err_s, 0);
    chk_z("rst_bus");
    r = 1'b1;
    @(negedge clk);

    // Fill both stores with known nonzero data using full-span bursts
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      for (int b = 0; b < 16; b++) begin
        for (int i = 0; i < 16; i++) wdat[i] = 16'($urandom_range(1, 65535));
        do_burst(16 * b, 15, 1'b1, 0, -1);
      end
    end
    sel = 1'b0;

    // Two known words then a back-to-back read
    wdat[0] = 16'h1234; wdat[1] = 16'hABCD;
    do_burst(0, 1, 1'b1, 0, -1);
    do_burst(0, 1, 1'b0, 0, -1);

    // Gapped write of three words, then read with neighbours
    wdat[0] = 16'hAAAA; wdat[1] = 16'h5555; wdat[2] = 16'h0F0F;
    do_burst(16, 2, 1'b1, 2, -1);
    do_burst(15, 4, 1'b0, -1, -1);

    // stb without oe is not a read beat
    do_burst(32, 2, 1'b0, 5, -1);

    // Range check table
    foreach (rt[n]) begin
      addr = 8'(rt[n].a); len = 4'(rt[n].l); we = rt[n].w; req = 1'b1;
      tb_en = rt[n].w; tb_dat = 16'hDEAD; stb = 1'b1; oe = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk("rng_err", err_s, rt[n].exp_err);
      chk("rng_busy", busy_s, !rt[n].exp_err);
      stb = 1'b0; tb_en = 1'b0;
      if (rt[n].exp_err) begin
        @(negedge clk);
        chk("rng_err_pulse", err_s, 0);
      end else begin
        oe = 1'b1; stb = 1'b1;
        for (int c = 0; c < 40 && busy_s; c++) @(negedge clk);
        chk("rng_drain", busy_s, 0);
        oe = 1'b0; stb = 1'b0;
      end
    end
    do_burst(240, 15, 1'b0, -1, -1);

    // Held out-of-range request pulses err every cycle
    addr = 8'd255; len = 4'd2; we = 1'b1; req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("held_err", err_s, 1);
      chk("held_busy", busy_s, 0);
    end
    req = 1'b0;
    @(negedge clk);
    chk("held_err_clear", err_s, 0);

    // Reset after 2 of 4 write beats
    for (int i = 0; i < 4; i++) wdat[i] = ~mdl[0][64+i];
    do_burst(64, 3, 1'b1, 0, 2);
    do_burst(64, 3, 1'b0, 0, -1);

    // No-seek instance: single-word reads back to back
    sel = 1'b1;
    do_burst(5, 0, 1'b0, 0, -1);
    do_burst(6, 0, 1'b0, 0, -1);

    // Randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      sel = 1'($urandom);
      l = int'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 255));
      w = 1'($urandom);
      if (a + l > 255) begin
        addr = 8'(a); len = 4'(l); we = w; req = 1'b1; tb_en = w; tb_dat = 16'h0BAD;
        @(posedge clk); #1;
        req = 1'b0; tb_en = 1'b0;
        @(negedge clk);
        chk("rnd_err", err_s, 1);
        chk("rnd_err_busy", busy_s, 0);
        @(negedge clk);
      end else begin
        for (int i = 0; i < 16; i++) wdat[i] = 16'($urandom_range(1, 65535));
        do_burst(a, l, w, -1, -1);
      end
    end

    // Final sweep of both stores
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      for (int b = 0; b < 16; b++) do_burst(16 * b, 15, 1'b0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
